i2c_burst_sequencer: RTL
========================

// Module: i2c_burst_sequencer
// PURPOSE
//  Parametrised successor to the single-byte I2C top level: turns one command (addr, rw, len) into a
//  burst of len byte transactions on the byte-level i2c_master_controller handshake.
//  Adds a write-data FIFO, read-data output with backpressure, per-byte NACK retry and a wait timeout.
//  Sits between system logic (clk domain) and the master controller; the slave side is untouched.
// PARAMETERS
//  ADDR_W     7     slave address width
//  DATA_W     8     data byte width
//  LEN_W      4     burst length field width; legal len 1..2^LEN_W-1
//  FIFO_DEPTH 8     write-data FIFO entries (power of 2)
//  MAX_RETRY  3     re-issues of a NACKed byte before error
//  TIMEOUT    1024  max clk cycles waiting for m_done per byte
// PORTS
//  clk        in   1       system clock, all logic on posedge
//  rst        in   1       reset, synchronous, active-low
//  cmd_valid  in   1       command offered
//  cmd_ready  out  1       command accepted when cmd_valid&cmd_ready
//  cmd_addr   in   ADDR_W  target slave address
//  cmd_rw     in   1       0=write, 1=read
//  cmd_len    in   LEN_W   bytes in burst
//  wr_valid   in   1       write byte offered to FIFO
//  wr_ready   out  1       FIFO not full
//  wr_data    in   DATA_W  write byte
//  rd_valid   out  1       read byte available
//  rd_ready   in   1       consumer takes rd_data when rd_valid&rd_ready
//  rd_data    out  DATA_W  read byte
//  m_start    out  1       1-cycle pulse: start one byte transaction
//  m_addr     out  ADDR_W  address to master (held from cmd)
//  m_rw       out  1       direction to master
//  m_wdata    out  DATA_W  byte to master, stable from m_start to m_done
//  m_done     in   1       1-cycle pulse: byte transaction finished
//  m_nack     in   1       valid with m_done: slave NACKed
//  m_rdata    in   DATA_W  valid with m_done on reads
//  busy       out  1       burst in progress
//  done       out  1       1-cycle pulse: burst completed (ok or error)
//  err        out  2       with done: 00 ok, 01 NACK exhausted, 10 timeout, 11 len=0
// BEHAVIOUR
//  Reset (rst=0 at posedge): state IDLE, FIFO empty, all counters 0; outputs cmd_ready=1, wr_ready=1,
//   rd_valid=0, rd_data=0, m_start=0, m_addr=0, m_rw=0, m_wdata=0, busy=0, done=0, err=0.
//   Reset mid-burst aborts immediately; no done pulse; FIFO contents discarded.
//  FIFO: write on wr_valid&wr_ready in any state; pop only in ISSUE for writes. Simultaneous push/pop
//   when full: wr_ready=0 so push is refused. Pointers wrap at FIFO_DEPTH; count 0..FIFO_DEPTH.
//  FSM: IDLE -> (cmd accepted) latch addr/rw/len, byte_cnt=0, retry=0, busy=1.
//   len=0: -> DONE, err=11, no m_start issued.
//   write: FILL waits FIFO non-empty, then ISSUE. read: ISSUE directly.
//   ISSUE: write pops FIFO head into m_wdata; m_start=1 one cycle; timer=0 -> WAIT.
//   WAIT: m_done&!m_nack -> read: capture m_rdata, -> RDOUT; write: -> NEXT.
//         m_done&m_nack -> retry<MAX_RETRY: retry++, re-ISSUE same byte (no pop); else DONE err=01.
//         timer reaches TIMEOUT-1 without m_done -> DONE err=10. m_done on that cycle wins.
//   RDOUT: rd_valid=1, rd_data held until rd_ready; then -> NEXT. Master not restarted meanwhile.
//   NEXT: byte_cnt++, retry=0; byte_cnt==len -> DONE err=00; else FILL/ISSUE.
//   DONE: done=1 one cycle, busy=0 -> IDLE. cmd_ready=1 only in IDLE.
//  Latency: cmd accept -> first m_start = 2 cycles (read or non-empty FIFO).
//  On error, unsent burst bytes stay in FIFO; caller flushes by reset.
//  m_done while not in WAIT is ignored.
// TESTING
//  1 write len=3, FIFO preloaded AA,55,0F -> 3 m_start, m_wdata AA,55,0F in order, done err=00.
//  2 read len=2, m_rdata 3C,C3, rd_ready low 5 cycles -> rd_data 3C held, then C3; no m_start while held.
//  3 write len=1, m_nack on first 2 attempts -> 3 m_start with same byte, err=00; 4 NACKs -> err=01.
//  4 m_done withheld -> done at TIMEOUT cycles after m_start, err=10; next cmd accepted.
//  5 cmd_len=0 -> done next cycle, err=11, zero m_start; FIFO fill to 8 -> wr_ready=0.
//  6 rst=0 during WAIT -> all outputs reset values next cycle, no done pulse.

Source files
------------

// File: rtl/i2c_burst_sequencer.sv
// Expands one (addr, rw, len) command into len byte transactions on the master handshake; cmd accept -> first m_start is 2 cycles.
// Backpressure: cmd_ready only in IDLE, wr_ready drops when the write FIFO is full, and RDOUT holds the master until rd_ready.
module i2c_burst_sequencer #(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 8,
    parameter int LEN_W      = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_RETRY  = 3,
    parameter int TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_rw,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              m_start,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_rw,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_done,
    input  logic              m_nack,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 2);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, FILL, ISSUE, WAIT, RDOUT, NEXT, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [RTY_W-1:0]  retry_q, retry_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              m_start_q, m_start_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [1:0]        err_q, err_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic              push, pop, fifo_nonempty;

    assign fifo_nonempty = (fifo_cnt_q != '0);
    assign wr_ready      = (fifo_cnt_q != CNT_W'(FIFO_DEPTH));
    assign push          = wr_valid && wr_ready;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        retry_d    = retry_q;
        timer_d    = timer_q;
        m_start_d  = 1'b0;
        m_wdata_d  = m_wdata_q;
        rd_data_d  = rd_data_q;
        err_d      = err_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: if (cmd_valid) begin
                addr_d     = cmd_addr;
                rw_d       = cmd_rw;
                len_d      = cmd_len;
                byte_cnt_d = '0;
                retry_d    = '0;
                if (cmd_len == '0) begin
                    state_d = DONE;
                    err_d   = 2'b11;
                end else if (cmd_rw || fifo_nonempty) state_d = ISSUE;
                else state_d = FILL;
            end
            FILL: if (fifo_nonempty) state_d = ISSUE;
            ISSUE: begin
                // A retried byte is already in m_wdata; only the first attempt pops.
                m_start_d = 1'b1;
                timer_d   = '0;
                if (!rw_q && retry_q == '0) begin
                    pop       = 1'b1;
                    m_wdata_d = mem_q[rd_ptr_q];
                end
                state_d = WAIT;
            end
            WAIT: begin
                timer_d = timer_q + 1'b1;
                if (m_done) begin
                    if (!m_nack) begin
                        if (rw_q) begin
                            rd_data_d = m_rdata;
                            state_d   = RDOUT;
                        end else state_d = NEXT;
                    end else if (retry_q < RTY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = ISSUE;
                    end else begin
                        err_d   = 2'b01;
                        state_d = DONE;
                    end
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    err_d   = 2'b10;
                    state_d = DONE;
                end
            end
            RDOUT: if (rd_ready) state_d = NEXT;
            NEXT: begin
                byte_cnt_d = byte_cnt_q + 1'b1;
                retry_d    = '0;
                if (byte_cnt_d == len_q) begin
                    err_d   = 2'b00;
                    state_d = DONE;
                end else if (rw_q || fifo_nonempty) state_d = ISSUE;
                else state_d = FILL;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rw_q       <= 1'b0;
            len_q      <= '0;
            byte_cnt_q <= '0;
            retry_q    <= '0;
            timer_q    <= '0;
            m_start_q  <= 1'b0;
            m_wdata_q  <= '0;
            rd_data_q  <= '0;
            err_q      <= 2'b00;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            retry_q    <= retry_d;
            timer_q    <= timer_d;
            m_start_q  <= m_start_d;
            m_wdata_q  <= m_wdata_d;
            rd_data_q  <= rd_data_d;
            err_q      <= err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign cmd_ready = (state_q == IDLE);
    assign rd_valid  = (state_q == RDOUT);
    assign rd_data   = rd_data_q;
    assign m_start   = m_start_q;
    assign m_addr    = addr_q;
    assign m_rw      = rw_q;
    assign m_wdata   = m_wdata_q;
    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign done      = (state_q == DONE);
    assign err       = err_q;
endmodule
